// File: rtl/lsu_align_pkg.sv
// Shared load/store definitions: DataMem access codes, the LSU state
// encoding (decoded by trace/debug logic) and the misalignment test.
package lsu_align_pkg;

  // DataMem fn3 access codes (loads and stores share the low encodings)
  localparam logic [2:0] FN3_LB  = 3'b000;
  localparam logic [2:0] FN3_LH  = 3'b001;
  localparam logic [2:0] FN3_LW  = 3'b010;
  localparam logic [2:0] FN3_LBU = 3'b100;
  localparam logic [2:0] FN3_LHU = 3'b101;
  localparam logic [2:0] FN3_SB  = 3'b000;
  localparam logic [2:0] FN3_SH  = 3'b001;
  localparam logic [2:0] FN3_SW  = 3'b010;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    RD1  = 3'd2,
    RDW  = 3'd3,
    ST   = 3'd4,
    RESP = 3'd5
  } lsu_state_t;

  // A half access is misaligned on an odd address, a word access on any
  // address not a multiple of four. LHU only exists as a load code.
  function automatic logic is_misaligned(input logic       we,
                                         input logic [2:0] fn3,
                                         input logic [1:0] off);
    logic half;
    logic word;
    half = (fn3 == FN3_LH) || (!we && (fn3 == FN3_LHU));
    word = (fn3 == FN3_LW);
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align_load_merge.sv
// Combines two consecutive aligned words into the result of a load that
// straddles them: byte-shift by the address offset, then extend per fn3.
module load_merge
  import lsu_align_pkg::*;
(
  input  logic [63:0] pair,
  input  logic [1:0]  off,
  input  logic [2:0]  fn3,
  output logic [31:0] result
);

  logic [31:0] window;

  // Select the 32-bit window starting at the addressed byte, then extend
  always_comb begin
    window = pair[{off, 3'b000} +: 32];
    case (fn3)
      FN3_LB:  result = {{24{window[7]}}, window[7:0]};
      FN3_LBU: result = {24'h0, window[7:0]};
      FN3_LH:  result = {{16{window[15]}}, window[15:0]};
      FN3_LHU: result = {16'h0, window[15:0]};
      default: result = window;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store front end for DataMem: passes aligned accesses through and
// splits misaligned ones into two LW reads or a run of SB writes.
module lsu_align
  import lsu_align_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_fn3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_split,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic [2:0]  mem_fn3,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state_reg, state_next;
  logic [2:0]  fn3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic        split_reg;
  logic [1:0]  k_reg;
  logic [31:0] lo_reg;
  logic [31:0] last_addr_reg;
  logic [31:0] resp_rdata_reg;

  logic        accept;
  logic [31:0] word_addr;
  logic [1:0]  k_last;
  logic        store_ok;
  logic [31:0] merged;

  assign accept     = req_valid && req_ready;
  assign word_addr  = {addr_reg[31:2], 2'b00};
  // Split stores are only SH (two bytes) or SW (four bytes)
  assign k_last     = (fn3_reg == FN3_SH) ? 2'd1 : 2'd3;
  assign store_ok   = (fn3_reg == FN3_SB) || (fn3_reg == FN3_SH) || (fn3_reg == FN3_SW);
  assign resp_valid = (state_reg == RESP);
  assign resp_rdata = resp_rdata_reg;
  assign resp_split = split_reg;

  load_merge u_load_merge (
    .pair   ({mem_rdata, lo_reg}),
    .off    (addr_reg[1:0]),
    .fn3    (fn3_reg),
    .result (merged)
  );

  // Next state and DataMem drive; mem_we is purely state-decoded so an
  // asynchronous reset removes it at once
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    mem_we     = 1'b0;
    mem_fn3    = FN3_LW;
    mem_addr   = last_addr_reg;
    mem_wdata  = 32'h0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_we ? ST : RD0;
      end
      RD0: begin
        mem_addr   = split_reg ? word_addr : addr_reg;
        mem_fn3    = split_reg ? FN3_LW : fn3_reg;
        state_next = split_reg ? RD1 : RDW;
      end
      RD1: begin
        mem_addr   = word_addr + 32'd4;
        state_next = RDW;
      end
      RDW: begin
        mem_addr   = split_reg ? (word_addr + 32'd4) : addr_reg;
        mem_fn3    = split_reg ? FN3_LW : fn3_reg;
        state_next = RESP;
      end
      ST: begin
        if (split_reg) begin
          mem_we    = 1'b1;
          mem_fn3   = FN3_SB;
          mem_addr  = addr_reg + {30'h0, k_reg};
          mem_wdata = {24'h0, wdata_reg[{k_reg, 3'b000} +: 8]};
          if (k_reg == k_last) state_next = RESP;
        end else begin
          mem_we     = store_ok;
          mem_fn3    = fn3_reg;
          mem_addr   = addr_reg;
          mem_wdata  = wdata_reg;
          state_next = RESP;
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, request capture, sub-access counter and load result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      fn3_reg        <= FN3_LW;
      addr_reg       <= 32'h0;
      wdata_reg      <= 32'h0;
      split_reg      <= 1'b0;
      k_reg          <= 2'd0;
      lo_reg         <= 32'h0;
      last_addr_reg  <= 32'h0;
      resp_rdata_reg <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (state_reg != IDLE) last_addr_reg <= mem_addr;
      if (accept) begin
        fn3_reg        <= req_fn3;
        addr_reg       <= req_addr;
        wdata_reg      <= req_wdata;
        split_reg      <= is_misaligned(req_we, req_fn3, req_addr[1:0]);
        k_reg          <= 2'd0;
        resp_rdata_reg <= 32'h0;
      end
      if (state_reg == ST)  k_reg  <= k_reg + 2'd1;
      if (state_reg == RD1) lo_reg <= mem_rdata;
      if (state_reg == RDW) resp_rdata_reg <= split_reg ? merged : mem_rdata;
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: a behavioural DataMem, directed requests with
// hand-computed results, and queue-based response/write scoreboards.
module tb_lsu_align;
  import lsu_align_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_fn3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_split;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [2:0]  mem_fn3;
  logic [31:0] mem_rdata;

  lsu_align dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_fn3    (req_fn3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_split (resp_split),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_fn3    (mem_fn3),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- DataMem model (1 KB, address bits [9:2]) ----------
  logic [31:0] mem_words [256];
  logic [31:0] rd_word = 32'h0;
  logic [1:0]  rd_off = 2'd0;

  function automatic logic [31:0] wr_merge(input logic [31:0] old, input logic [2:0] fn3,
                                           input logic [1:0] off, input logic [31:0] d);
    logic [31:0] w;
    w = old;
    case (fn3)
      FN3_SB:  w[{off, 3'b000} +: 8] = d[7:0];
      FN3_SH:  w[{off[1], 4'b0000} +: 16] = d[15:0];
      default: w = d;
    endcase
    return w;
  endfunction

  always @(posedge clk) begin
    rd_word <= mem_words[mem_addr[9:2]];
    rd_off  <= mem_addr[1:0];
    if (mem_we)
      mem_words[mem_addr[9:2]] <= wr_merge(mem_words[mem_addr[9:2]], mem_fn3, mem_addr[1:0], mem_wdata);
  end

  always_comb begin
    logic [31:0] sh;
    sh = rd_word >> {rd_off, 3'b000};
    case (mem_fn3)
      FN3_LB:  mem_rdata = {{24{sh[7]}}, sh[7:0]};
      FN3_LBU: mem_rdata = {24'h0, sh[7:0]};
      FN3_LH:  mem_rdata = {{16{sh[15]}}, sh[15:0]};
      FN3_LHU: mem_rdata = {16'h0, sh[15:0]};
      default: mem_rdata = rd_word;
    endcase
  end

  // ---------------- scoreboards ----------------
  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        split;
    int          lat;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  resp_t exp_q[$];
  wr_t   wr_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    acc_cyc = 0;
  int    n_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_resp(input string name, input logic [31:0] rdata, input logic split, input int lat);
    resp_t r;
    r.name = name; r.rdata = rdata; r.split = split; r.lat = lat;
    exp_q.push_back(r);
  endtask

  task automatic push_wr(input logic [31:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr; w.data = data;
    wr_q.push_back(w);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: accepts, responses and DataMem write pulses, sampled mid-cycle
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (req_valid && req_ready) begin
        acc_cyc = cyc;
        n_acc++;
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp actual=%h required=none", resp_rdata);
        end else begin
          resp_t r;
          r = exp_q.pop_front();
          $display("resp %s rdata=%h split=%0d lat=%0d", r.name, resp_rdata, resp_split, cyc - acc_cyc);
          chk({r.name, "_rdata"}, resp_rdata, r.rdata);
          chk({r.name, "_split"}, {31'h0, resp_split}, {31'h0, r.split});
          chk({r.name, "_lat"}, cyc - acc_cyc, r.lat);
        end
      end
      if (mem_we) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write actual=%h required=none", mem_addr);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          $display("write addr=%h data=%h fn3=%0d", mem_addr, mem_wdata, mem_fn3);
          chk("write_addr", mem_addr, w.addr);
          chk("write_data", mem_wdata, w.data);
          chk("write_fn3", {29'h0, mem_fn3}, {29'h0, FN3_SB});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int budget;
    budget = 0;
    @(posedge clk); #1;
    while (!req_ready && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!req_ready) chk("req_ready_timeout", {31'h0, req_ready}, 32'h1);
  endtask

  // Returns #1 after the accepting edge, i.e. early in cycle 1
  task automatic issue(input logic we, input logic [2:0] fn3, input logic [31:0] addr, input logic [31:0] wdata);
    wait_ready();
    req_valid = 1'b1; req_we = we; req_fn3 = fn3; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  logic [31:0] a1, a2;
  int          n0;

  initial begin
    for (int i = 0; i < 256; i++) mem_words[i] = 32'h0;
    mem_words[8'h40] = 32'h4433_2211;   // 0x100
    mem_words[8'h41] = 32'h8877_6655;   // 0x104
    mem_words[8'hFF] = 32'hA1B2_C3D4;   // 0xFFFF_FFFC
    mem_words[8'h00] = 32'h0807_0605;   // 0x0000_0000

    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_split", {31'h0, resp_split}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_fn3", {29'h0, mem_fn3}, {29'h0, FN3_LW});
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);

    push_resp("lw_100", 32'h4433_2211, 1'b0, 3);
    issue(1'b0, FN3_LW, 32'h100, 32'h0);

    push_resp("lw_102", 32'h6655_4433, 1'b1, 4);
    issue(1'b0, FN3_LW, 32'h102, 32'h0);
    @(negedge clk) a1 = mem_addr;
    @(negedge clk) a2 = mem_addr;
    chk("lw_102_addr0", a1, 32'h100);
    chk("lw_102_addr1", a2, 32'h104);

    push_resp("lh_103", 32'h0000_5544, 1'b1, 4);
    issue(1'b0, FN3_LH, 32'h103, 32'h0);

    push_resp("lb_107", 32'hFFFF_FF88, 1'b0, 3);
    issue(1'b0, FN3_LB, 32'h107, 32'h0);

    push_wr(32'h101, 32'hAA); push_wr(32'h102, 32'hBB);
    push_wr(32'h103, 32'hCC); push_wr(32'h104, 32'hDD);
    push_resp("sw_101", 32'h0, 1'b1, 5);
    issue(1'b1, FN3_SW, 32'h101, 32'hDDCC_BBAA);

    push_resp("lw_100_after", 32'hCCBB_AA11, 1'b0, 3);
    issue(1'b0, FN3_LW, 32'h100, 32'h0);
    push_resp("lw_104_after", 32'h8877_66DD, 1'b0, 3);
    issue(1'b0, FN3_LW, 32'h104, 32'h0);

    // Reset during the second SB of a repeated split store
    push_wr(32'h101, 32'hAA);
    issue(1'b1, FN3_SW, 32'h101, 32'hDDCC_BBAA);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("midrst_resp_valid", {31'h0, resp_valid}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_req_ready", {31'h0, req_ready}, 32'h1);
    push_resp("lbu_101", 32'h0000_00AA, 1'b0, 3);
    issue(1'b0, FN3_LBU, 32'h101, 32'h0);

    push_resp("lw_wrap", 32'h0605_A1B2, 1'b1, 4);
    issue(1'b0, FN3_LW, 32'hFFFF_FFFE, 32'h0);
    @(negedge clk) a1 = mem_addr;
    @(negedge clk) a2 = mem_addr;
    chk("wrap_addr0", a1, 32'hFFFF_FFFC);
    chk("wrap_addr1", a2, 32'h0000_0000);

    // Hold req_valid across a whole split store: second accept only after RESP
    for (int j = 0; j < 2; j++) begin
      push_wr(32'h101, 32'hAA); push_wr(32'h102, 32'hBB);
      push_wr(32'h103, 32'hCC); push_wr(32'h104, 32'hDD);
      push_resp("sw_hold", 32'h0, 1'b1, 5);
    end
    wait_ready();
    n0 = n_acc;
    req_valid = 1'b1; req_we = 1'b1; req_fn3 = FN3_SW; req_addr = 32'h101; req_wdata = 32'hDDCC_BBAA;
    repeat (7) @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("hold_accepts", n_acc - n0, 32'd2);

    push_resp("st_fn3_3", 32'h0, 1'b0, 2);
    issue(1'b1, 3'd3, 32'h100, 32'h1234_5678);

    push_resp("lw_100_final", 32'hCCBB_AA11, 1'b0, 3);
    issue(1'b0, FN3_LW, 32'h100, 32'h0);

    for (int t = 0; t < 200 && (exp_q.size() != 0 || wr_q.size() != 0); t++) @(posedge clk);
    repeat (4) @(posedge clk);
    chk("resp_queue_empty", exp_q.size(), 32'd0);
    chk("write_queue_empty", wr_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
